// File: rtl/muldiv_pkg.sv
// Shared types for the Execute-stage multiply/divide unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: md_op_t (decoder E-stage field), md_state_t (unit FSM), MD_WIDTH.
package muldiv_pkg;

  localparam int MD_WIDTH = 32;

  // Encoding is shared with the main decoder's E-stage field; do not reorder.
  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_t;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIX  = 2'd2
  } md_state_t;

endpackage

// File: rtl/flopenr.sv
// Enabled register with synchronous active-high reset.
// Latency: 1 cycle from d/en to q.
// Backpressure: none; en is the only qualifier.
//
// Ports: clk, reset, en, d[WIDTH] -> q[WIDTH].
module flopenr #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset)   q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/md_step.sv
// One radix-2 iteration of the multiply/divide datapath (combinational).
// Latency: 0 cycles.
// Backpressure: none; the caller decides when to register the outputs.
//
// Ports: op_i selects shift-add multiply or restoring divide; acc_i/acc_o is the
// WIDTH+1-bit accumulator, a_i/a_o the shifting operand (multiplier bits out /
// quotient bits in), b_i the fixed multiplicand or divisor magnitude.
module md_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  md_op_t           op_i,
  input  logic [WIDTH:0]   acc_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH:0]   acc_o,
  output logic [WIDTH-1:0] a_o
);

  logic             is_div;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shl;
  logic [WIDTH+1:0] diff;

  assign is_div = (op_i == MD_DIV) || (op_i == MD_DIVU);

  always_comb begin
    sum   = {1'b0, acc_i[WIDTH-1:0]} + {1'b0, b_i};
    // Partial remainder shifted left with the next dividend bit brought in.
    shl   = {acc_i[WIDTH-1:0], a_i[WIDTH-1]};
    // Extra top bit acts as the borrow flag of the trial subtraction.
    diff  = {1'b0, shl} - {2'b00, b_i};
    acc_o = acc_i;
    a_o   = a_i;
    if (is_div) begin
      if (!diff[WIDTH+1]) begin
        acc_o = diff[WIDTH:0];
        a_o   = {a_i[WIDTH-2:0], 1'b1};
      end else begin
        acc_o = shl;
        a_o   = {a_i[WIDTH-2:0], 1'b0};
      end
    end else begin
      // {acc, a} >> 1 after optionally adding the multiplicand into the top half;
      // the bit shifted out of acc becomes the next finished product bit.
      if (a_i[0]) begin
        acc_o = {1'b0, sum[WIDTH:1]};
        a_o   = {sum[0], a_i[WIDTH-1:1]};
      end else begin
        acc_o = acc_i >> 1;
        a_o   = {acc_i[0], a_i[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative mult/multu/div/divu unit with architectural HI/LO and mthi/mtlo.
// Latency: start at cycle 0, busy cycles 1..WIDTH+1, HI/LO and done at WIDTH+2.
// Backpressure: busy tells the hazard unit to stall; starts while busy are dropped.
//
// Ports: clk, reset (sync, high); startE/opE/srcaE/srcbE launch an op; cancelE aborts
// it; wrhiW/wrloW/wdW are mthi/mtlo; outputs hi, lo, busy, done, divzero.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             startE,
  input  md_op_t           opE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  input  logic             cancelE,
  input  logic             wrhiW,
  input  logic             wrloW,
  input  logic [WIDTH-1:0] wdW,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             divzero
);

  localparam int CW = $clog2(WIDTH);

  md_state_t        state_q;
  md_op_t           op_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   acc_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             res_neg_q;
  logic             rem_neg_q;
  logic             divzero_q;
  logic             done_q;

  logic [WIDTH:0]     acc_d;
  logic [WIDTH-1:0]   a_d;
  logic               e_signed, e_div, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               start_acc, fix_wr, idle, q_div;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;
  logic [WIDTH-1:0]   hi_d, lo_d;
  logic               hi_en, lo_en;

  md_step #(.WIDTH(WIDTH)) u_step (
    .op_i  (op_q),
    .acc_i (acc_q),
    .a_i   (a_q),
    .b_i   (b_q),
    .acc_o (acc_d),
    .a_o   (a_d)
  );

  assign idle      = (state_q == MD_IDLE);
  assign busy      = !idle;
  assign done      = done_q;
  assign divzero   = divzero_q;
  assign start_acc = idle && startE && !cancelE;
  assign fix_wr    = (state_q == MD_FIX) && !cancelE;

  // Operand magnitudes and signs for the op being launched.
  assign e_signed = (opE == MD_MULT) || (opE == MD_DIV);
  assign e_div    = (opE == MD_DIV) || (opE == MD_DIVU);
  assign a_neg    = e_signed && srcaE[WIDTH-1];
  assign b_neg    = e_signed && srcbE[WIDTH-1];
  assign a_mag    = a_neg ? (WIDTH'(0) - srcaE) : srcaE;
  assign b_mag    = b_neg ? (WIDTH'(0) - srcbE) : srcbE;

  // Sign correction applied while in FIX.
  assign q_div    = (op_q == MD_DIV) || (op_q == MD_DIVU);
  assign prod     = {acc_q[WIDTH-1:0], a_q};
  assign prod_fix = res_neg_q ? ((2*WIDTH)'(0) - prod) : prod;
  // A zero divisor yields an all-ones quotient regardless of signs. The remainder
  // path already reproduces the raw dividend, since it ends up as the signed |a|.
  assign quot_fix = divzero_q ? '1 : (res_neg_q ? (WIDTH'(0) - a_q) : a_q);
  assign rem_fix  = rem_neg_q ? (WIDTH'(0) - acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];

  // A start accepted in the same cycle wins over mthi/mtlo.
  assign hi_en = fix_wr || (idle && wrhiW && !start_acc);
  assign lo_en = fix_wr || (idle && wrloW && !start_acc);
  assign hi_d  = fix_wr ? (q_div ? rem_fix  : prod_fix[2*WIDTH-1:WIDTH]) : wdW;
  assign lo_d  = fix_wr ? (q_div ? quot_fix : prod_fix[WIDTH-1:0])       : wdW;

  flopenr #(.WIDTH(WIDTH)) u_hi (.clk(clk), .reset(reset), .en(hi_en), .d(hi_d), .q(hi));
  flopenr #(.WIDTH(WIDTH)) u_lo (.clk(clk), .reset(reset), .en(lo_en), .d(lo_d), .q(lo));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= MD_IDLE;
      op_q      <= MD_MULT;
      cnt_q     <= '0;
      acc_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      res_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      divzero_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        MD_IDLE: begin
          if (start_acc) begin
            op_q      <= opE;
            a_q       <= a_mag;
            b_q       <= b_mag;
            res_neg_q <= a_neg ^ b_neg;
            rem_neg_q <= a_neg;
            acc_q     <= '0;
            cnt_q     <= '0;
            divzero_q <= e_div && (srcbE == '0);
            state_q   <= MD_RUN;
          end
        end
        MD_RUN: begin
          if (cancelE) begin
            state_q <= MD_IDLE;
          end else begin
            acc_q <= acc_d;
            a_q   <= a_d;
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) state_q <= MD_FIX;
          end
        end
        MD_FIX: begin
          state_q <= MD_IDLE;
          done_q  <= !cancelE;
        end
        default: state_q <= MD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases, timing/cancel/reset, random ops.
// Latency: n/a.
// Backpressure: n/a.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         startE;
  md_op_t       opE;
  logic [W-1:0] srcaE, srcbE;
  logic         cancelE, wrhiW, wrloW;
  logic [W-1:0] wdW;
  logic [W-1:0] hi, lo;
  logic         busy, done, divzero;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_hi, exp_lo;
  logic         exp_dz;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .startE(startE), .opE(opE), .srcaE(srcaE), .srcbE(srcbE),
    .cancelE(cancelE), .wrhiW(wrhiW), .wrloW(wrloW), .wdW(wdW),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .divzero(divzero)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Outputs are observed 1ns after the rising edge; inputs driven then hold for the cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Architectural reference: plain 64-bit arithmetic on the MIPS rules.
  function automatic void model(input md_op_t op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] mhi, output logic [W-1:0] mlo,
                                output logic mdz);
    longint      sa, sb, q, r;
    logic [63:0] p, qv, rv;
    mdz = 1'b0;
    mhi = '0;
    mlo = '0;
    case (op)
      MD_MULT, MD_MULTU: begin
        if (op == MD_MULT) begin
          sa = longint'($signed(a));
          sb = longint'($signed(b));
        end else begin
          sa = longint'({32'd0, a});
          sb = longint'({32'd0, b});
        end
        p   = 64'(sa * sb);
        mhi = p[63:32];
        mlo = p[31:0];
      end
      default: begin
        if (b == '0) begin
          mdz = 1'b1;
          mlo = '1;
          mhi = a;
        end else begin
          if (op == MD_DIV) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
          end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
          end
          q   = sa / sb;
          r   = sa % sb;
          qv  = 64'(q);
          rv  = 64'(r);
          mlo = qv[31:0];
          mhi = rv[31:0];
        end
      end
    endcase
  endfunction

  // Launch in the current cycle (cycle 0); returns in the done cycle.
  task automatic run_op(input md_op_t op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic with_mthi);
    logic [W-1:0] eh, el;
    logic         ed;
    int           done_at;
    int           busy_cnt;
    logic [W-1:0] prev_hi;
    done_at  = -1;
    busy_cnt = 0;
    prev_hi  = exp_hi;
    model(op, a, b, eh, el, ed);
    opE    = op;
    srcaE  = a;
    srcbE  = b;
    startE = 1'b1;
    wrhiW  = with_mthi;
    wdW    = 32'h0000_AAAA;
    for (int c = 1; c <= 40 && done_at < 0; c++) begin
      tick();
      startE = 1'b0;
      wrhiW  = 1'b0;
      if (c == 1 && with_mthi) check("mthi_dropped_on_start", hi, prev_hi);
      if (busy) busy_cnt++;
      if (done) done_at = c;
    end
    check($sformatf("%s done_cycle", op.name()), 64'(done_at), 64'd34);
    check($sformatf("%s busy_cycles", op.name()), 64'(busy_cnt), 64'd33);
    check($sformatf("%s %0h,%0h hi", op.name(), a, b), hi, eh);
    check($sformatf("%s %0h,%0h lo", op.name(), a, b), lo, el);
    check($sformatf("%s divzero", op.name()), divzero, ed);
    exp_hi = eh;
    exp_lo = el;
    exp_dz = ed;
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] edge_vals [5];
    edge_vals[0] = 32'h0000_0000;
    edge_vals[1] = 32'h0000_0001;
    edge_vals[2] = 32'hFFFF_FFFF;
    edge_vals[3] = 32'h8000_0000;
    edge_vals[4] = 32'h7FFF_FFFF;
    if ($urandom_range(3) == 0) return edge_vals[$urandom_range(4)];
    if ($urandom_range(1) == 0) return W'($urandom_range(20));
    return W'($urandom);
  endfunction

  initial begin
    logic [W-1:0] eh, el;
    logic         ed;
    int           done_seen;

    reset   = 1'b1;
    startE  = 1'b0;
    opE     = MD_MULT;
    srcaE   = '0;
    srcbE   = '0;
    cancelE = 1'b0;
    wrhiW   = 1'b0;
    wrloW   = 1'b0;
    wdW     = '0;
    tick();
    tick();
    check("reset hi", hi, 0);
    check("reset lo", lo, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset divzero", divzero, 0);
    reset  = 1'b0;
    exp_hi = '0;
    exp_lo = '0;
    exp_dz = 1'b0;
    tick();

    // mthi in IDLE is visible the next cycle.
    wrhiW = 1'b1;
    wdW   = 32'hCAFE_0001;
    tick();
    wrhiW = 1'b0;
    check("mthi idle", hi, 32'hCAFE_0001);
    exp_hi = 32'hCAFE_0001;
    tick();

    // Directed cases; back-to-back starts land in each done cycle.
    run_op(MD_MULT,  32'hFFFF_FFFF, 32'h0000_0002, 1'b1);
    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
    run_op(MD_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
    run_op(MD_DIVU,  32'h0000_0007, 32'h0000_0002, 1'b0);
    run_op(MD_DIVU,  32'h0000_0005, 32'h0000_0000, 1'b0);
    run_op(MD_MULT,  32'h0000_0003, 32'h0000_0004, 1'b0);
    run_op(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(MD_DIV,   32'h8000_0000, 32'h0000_0001, 1'b0);
    run_op(MD_DIV,   32'hFFFF_FFF0, 32'h0000_0000, 1'b0);

    // Timing: ignored start while busy, ignored mtlo in RUN, mtlo later in IDLE.
    model(MD_MULTU, 32'h0001_0001, 32'h0000_0010, eh, el, ed);
    opE    = MD_MULTU;
    srcaE  = 32'h0001_0001;
    srcbE  = 32'h0000_0010;
    startE = 1'b1;
    for (int c = 1; c <= 42; c++) begin
      tick();
      startE = 1'b0;
      wrloW  = 1'b0;
      check($sformatf("timing busy c%0d", c), busy, (c >= 1 && c <= 33));
      check($sformatf("timing done c%0d", c), done, (c == 34));
      if (c == 11) check("mtlo ignored in RUN", lo, exp_lo);
      if (c == 34) begin
        check("timing hi", hi, eh);
        check("timing lo", lo, el);
      end
      if (c == 41) begin
        check("mtlo lo", lo, 32'h0000_1234);
        check("mtlo keeps hi", hi, eh);
      end
      if (c == 5) begin
        opE    = MD_DIVU;
        srcaE  = 32'd100;
        srcbE  = 32'd3;
        startE = 1'b1;
      end
      if (c == 10) begin
        wrloW = 1'b1;
        wdW   = 32'hDEAD_BEEF;
      end
      if (c == 40) begin
        wrloW = 1'b1;
        wdW   = 32'h0000_1234;
      end
    end
    exp_hi = eh;
    exp_lo = 32'h0000_1234;
    exp_dz = 1'b0;

    // Cancel of a div-by-zero in cycle 10: HI/LO kept, divzero as set at start.
    opE       = MD_DIV;
    srcaE     = 32'd77;
    srcbE     = 32'd0;
    startE    = 1'b1;
    done_seen = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      startE  = 1'b0;
      cancelE = (c == 10);
      if (done) done_seen++;
      if (c == 11) check("cancel busy", busy, 0);
    end
    check("cancel no done", 64'(done_seen), 0);
    check("cancel hi", hi, exp_hi);
    check("cancel lo", lo, exp_lo);
    check("cancel divzero", divzero, 1);

    // Cancel in IDLE blocks a same-cycle start.
    opE     = MD_MULT;
    startE  = 1'b1;
    cancelE = 1'b1;
    tick();
    startE  = 1'b0;
    cancelE = 1'b0;
    check("idle cancel blocks start", busy, 0);

    // Reset in cycle 20 of an operation.
    opE    = MD_DIV;
    srcaE  = 32'd1000;
    srcbE  = 32'd0;
    startE = 1'b1;
    for (int c = 1; c <= 21; c++) begin
      tick();
      startE = 1'b0;
      reset  = (c == 20);
      if (c == 21) begin
        check("midop reset hi", hi, 0);
        check("midop reset lo", lo, 0);
        check("midop reset busy", busy, 0);
        check("midop reset divzero", divzero, 0);
      end
    end
    reset  = 1'b0;
    exp_hi = '0;
    exp_lo = '0;
    tick();

    // Random operations against the arithmetic model.
    for (int i = 0; i < 30; i++) begin
      md_op_t rop;
      rop = md_op_t'($urandom_range(3));
      run_op(rop, pick(), pick(), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit in the Execute stage of the pipelined MIPS core. It takes a decoded mult/multu/div/divu operation and the E-stage source operands, and computes the 2·WIDTH-bit result over WIDTH+1 cycles. The result is written into architectural HI/LO registers. The unit raises `busy` while working so the hazard unit can stall dependent mfhi/mflo and further muldiv instructions. It also services mthi/mtlo writes and a cancel from E-stage flush.

## Interface
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- startE  in  1  request to start the operation in opE (one cycle).
- opE  in  2  md_op_t: MD_MULT, MD_MULTU, MD_DIV, MD_DIVU.
- srcaE  in  WIDTH  multiplicand / dividend.
- srcbE  in  WIDTH  multiplier / divisor.
- cancelE  in  1  abort the in-flight operation (E-stage flush).
- wrhiW  in  1  mthi write enable.
- wrloW  in  1  mtlo write enable.
- wdW  in  WIDTH  mthi/mtlo data.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- busy  out  1  high while state is RUN or FIX.
- done  out  1  one-cycle pulse after HI/LO receive a result.
- divzero  out  1  sticky until next accepted start; set when a div/divu has srcbE==0.

## Operation
- States (md_state_t): IDLE, RUN, FIX.
- IDLE:
  - `startE` is accepted only in IDLE with `cancelE`=0.
  - On accept, the unit latches the magnitudes of the operands: |srca| and |srcb| for signed ops, raw values for unsigned ops. It also latches the result sign and remainder sign, and the op.
  - It then clears the WIDTH+1-bit accumulator and the counter, and clears `divzero` (sets it instead if a div has a zero divisor). Next state is RUN.
- RUN: one radix-2 step per cycle; the counter counts 0..WIDTH-1. After step WIDTH-1 the next state is FIX.
  - mult: shift-add into a 2·WIDTH-bit product.
  - div: restoring divide; quotient in the low half, remainder in the high half.
- FIX: apply the sign.
  - mult: negate the 2·WIDTH product if the result sign is negative.
  - div: negate the quotient if operand signs differ; the remainder takes the dividend's sign.
  - Write HI/LO, assert `done` next cycle, go to IDLE.
- Division by zero, either signedness: lo = all ones, hi = dividend (raw srcaE), divzero=1. The iteration still runs its full length.
- Signed INT_MIN / −1: lo=INT_MIN, hi=0. This falls out of the magnitude arithmetic; no special case.
- mthi/mtlo:
  - Applied only in IDLE. In RUN or FIX they are ignored, because the hazard unit guarantees they never occur there.
  - `startE` accepted in the same cycle takes priority and the write is dropped.
- `cancelE` in RUN or FIX: next state is IDLE, HI/LO and `divzero` unchanged, no `done`. In IDLE it has no effect and blocks a same-cycle start.
- `startE` while busy: ignored, no side effects.

## Timing
- Reset values: state=IDLE, hi=0, lo=0, busy=0, done=0, divzero=0, counter=0, accumulator=0. Reset mid-operation discards the operation.
- Start sampled at the end of cycle 0.
  - RUN occupies cycles 1..WIDTH.
  - FIX is cycle WIDTH+1; HI/LO update at the end of it.
  - `done`=1 in cycle WIDTH+2.
- `busy` is a combinational decode of state, so it is high for exactly WIDTH+1 cycles (1..WIDTH+1).
- A new start may be accepted in cycle WIDTH+2, the same cycle as `done`.
- HI/LO outputs are registers: mthi/mtlo data is visible the cycle after the write.
- No combinational path from any input to hi/lo/done/divzero.

## Structure
- `muldiv_pkg` holds:
  - md_op_t (2-bit enum: MULT=0, MULTU=1, DIV=2, DIVU=3), shared with the main decoder's E-stage field.
  - md_state_t.
  - The WIDTH default constant.
- HI and LO use the existing flopenr register primitive, with enables from FIX/mthi/mtlo.
- One sub-module is natural: `md_step`, the combinational single-step datapath. It takes the op, accumulator and operand and produces the next accumulator and next shifted operand. The FSM, counter and sign handling stay in `muldiv_unit`.

## Test plan
- mult 0xFFFFFFFF×0x00000002 → hi=0xFFFFFFFF, lo=0xFFFFFFFE. multu with the same operands → hi=0x00000001, lo=0xFFFFFFFE.
- div 0xFFFFFFF9 (−7) / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu 7/2 → lo=3, hi=1.
- divu 5/0 → lo=0xFFFFFFFF, hi=5, divzero=1, done in cycle 34. A following mult clears divzero.
- div 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0. div 0x80000000 / 1 → lo=0x80000000, hi=0.
- Start at cycle 0 → busy high cycles 1..33, done only in cycle 34. A second start at cycle 5 is ignored. mtlo at cycle 10 is ignored. mtlo 0x1234 at cycle 40 → lo=0x1234 in cycle 41.
- Cancel in cycle 10 → busy=0 in cycle 11, HI/LO keep the previous values, no done. Reset in cycle 20 of a new operation → hi=lo=0, busy=0 next cycle.
